// File: rtl/card_generation_unit.sv
// Card source for the blackjack controller: draws two card values per request
// (random or test sequences) and debounces one push-button input.
module card_generation_unit #(
   parameter logic [15:0] LFSR_SEED       = 16'hACE1,
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       on,
   input  logic [2:0] test,
   output logic [3:0] card1_out,
   output logic [3:0] card2_out,
   input  logic       btn_in,
   output logic       btn_db
);

   typedef enum logic [1:0] {
      MODE_RANDOM,
      MODE_SEQ,
      MODE_BLACKJACK,
      MODE_PAIR
   } mode_t;

   localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [15:0]   r_lfsr;
   logic [3:0]    r_rank;
   logic [3:0]    r_card1;
   logic [3:0]    r_card2;
   logic          r_sync1;
   logic          r_sync2;
   logic [CW-1:0] r_cnt;
   logic          r_db;

   mode_t       w_mode;
   logic [15:0] w_lfsr_next;
   logic [3:0]  w_rank_p1;
   logic [3:0]  w_rank_p2;
   logic [3:0]  w_card1;
   logic [3:0]  w_card2;

   // Nibble 0..15 folded onto ranks 1..13.
   function automatic logic [3:0] f_nib_rank(input logic [3:0] nib);
      return (nib >= 4'd13) ? nib - 4'd12 : nib + 4'd1;
   endfunction

   function automatic logic [3:0] f_val(input logic [3:0] rank);
      return (rank > 4'd10) ? 4'd10 : rank;
   endfunction

   always_comb begin
      w_mode = MODE_RANDOM;
      if (!test[2]) begin
         case (test[1:0])
            2'b01:   w_mode = MODE_SEQ;
            2'b10:   w_mode = MODE_BLACKJACK;
            2'b11:   w_mode = MODE_PAIR;
            default: w_mode = MODE_RANDOM;
         endcase
      end
   end

   always_comb begin
      w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
      w_rank_p1   = (r_rank == 4'd13) ? 4'd1 : r_rank + 4'd1;
      w_rank_p2   = (r_rank >= 4'd12) ? r_rank - 4'd11 : r_rank + 4'd2;
   end

   always_comb begin
      w_card1 = f_val(f_nib_rank(r_lfsr[3:0]));
      w_card2 = f_val(f_nib_rank(r_lfsr[7:4]));
      case (w_mode)
         MODE_SEQ: begin
            w_card1 = f_val(r_rank);
            w_card2 = f_val(w_rank_p1);
         end
         MODE_BLACKJACK: begin
            w_card1 = 4'd1;
            w_card2 = 4'd10;
         end
         MODE_PAIR: begin
            w_card1 = 4'd8;
            w_card2 = 4'd8;
         end
         default: ;
      endcase
   end

   // LFSR free-runs so the moment of a draw contributes entropy.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_lfsr  <= LFSR_SEED;
         r_rank  <= 4'd1;
         r_card1 <= '0;
         r_card2 <= '0;
      end else begin
         r_lfsr <= w_lfsr_next;
         if (on) begin
            r_card1 <= w_card1;
            r_card2 <= w_card2;
            if (w_mode == MODE_SEQ)
               r_rank <= w_rank_p2;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_cnt   <= '0;
         r_db    <= 1'b0;
      end else begin
         r_sync1 <= btn_in;
         r_sync2 <= r_sync1;
         if (r_sync2 == r_db) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_LAST) begin
            r_db  <= r_sync2;
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign card1_out = r_card1;
   assign card2_out = r_card2;
   assign btn_db    = r_db;

endmodule

// File: tb/tb_card_generation_unit.sv
// Self-checking bench for card_generation_unit: vector table for the test modes,
// LFSR-based model for random draws, hand sequences for reset and debouncing.
module tb_card_generation_unit;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       on = 1'b0;
   logic [2:0] test = 3'b000;
   logic       btn_in = 1'b0;
   logic [3:0] card1_out;
   logic [3:0] card2_out;
   logic       btn_db;

   int n_tests = 0;
   int n_fail  = 0;

   card_generation_unit #(
      .LFSR_SEED      (16'hACE1),
      .DEBOUNCE_CYCLES(16)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .on       (on),
      .test     (test),
      .card1_out(card1_out),
      .card2_out(card2_out),
      .btn_in   (btn_in),
      .btn_db   (btn_db)
   );

   always #5 clk = ~clk;

   // Clock edges since the last reset release.
   int unsigned ecnt;
   always @(posedge clk or posedge reset) begin
      if (reset) ecnt <= 0;
      else       ecnt <= ecnt + 1;
   end

   typedef struct {
      logic [2:0] test;
      logic       on;
      logic [3:0] e1;
      logic [3:0] e2;
   } vec_t;

   vec_t        tbl[18];
   logic [15:0] seq[8192];
   int          hist[11];

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int card_of_nib(input int nib);
      int rank;
      rank = (nib % 13) + 1;
      return (rank > 10) ? 10 : rank;
   endfunction

   initial begin
      int unsigned x;
      int n;
      int lows;
      int prev1, prev2;

      x = 16'hACE1;
      for (int i = 0; i < 8192; i++) begin
         seq[i] = x[15:0];
         x = (x & 1) ? ((x >> 1) ^ 32'hB400) : (x >> 1);
      end
      for (int v = 0; v < 11; v++) hist[v] = 0;

      tbl[0]  = '{3'b001, 1'b1, 4'd1,  4'd2};
      tbl[1]  = '{3'b001, 1'b0, 4'd1,  4'd2};
      tbl[2]  = '{3'b001, 1'b1, 4'd3,  4'd4};
      tbl[3]  = '{3'b001, 1'b1, 4'd5,  4'd6};
      tbl[4]  = '{3'b001, 1'b1, 4'd7,  4'd8};
      tbl[5]  = '{3'b001, 1'b1, 4'd9,  4'd10};
      tbl[6]  = '{3'b001, 1'b1, 4'd10, 4'd10};
      tbl[7]  = '{3'b001, 1'b1, 4'd10, 4'd1};
      tbl[8]  = '{3'b001, 1'b1, 4'd2,  4'd3};
      tbl[9]  = '{3'b010, 1'b0, 4'd2,  4'd3};
      tbl[10] = '{3'b010, 1'b1, 4'd1,  4'd10};
      tbl[11] = '{3'b011, 1'b1, 4'd8,  4'd8};
      tbl[12] = '{3'b011, 1'b1, 4'd8,  4'd8};
      tbl[13] = '{3'b011, 1'b1, 4'd8,  4'd8};
      tbl[14] = '{3'b011, 1'b1, 4'd8,  4'd8};
      tbl[15] = '{3'b001, 1'b1, 4'd4,  4'd5};
      tbl[16] = '{3'b011, 1'b0, 4'd4,  4'd5};
      tbl[17] = '{3'b101, 1'b0, 4'd4,  4'd5};

      // Reset state
      #12;
      chk("rst_card1", card1_out, 0);
      chk("rst_card2", card2_out, 0);
      chk("rst_btn_db", btn_db, 0);
      @(posedge clk);
      #1 reset = 1'b0;
      tick();
      chk("idle_card1", card1_out, 0);
      chk("idle_card2", card2_out, 0);

      // Deterministic modes
      for (int i = 0; i < 18; i++) begin
         test = tbl[i].test;
         on   = tbl[i].on;
         tick();
         chk($sformatf("vec%0d_card1", i), card1_out, tbl[i].e1);
         chk($sformatf("vec%0d_card2", i), card2_out, tbl[i].e2);
      end
      on = 1'b0;

      // Random draws against the LFSR model
      prev1 = card1_out;
      prev2 = card2_out;
      for (int i = 0; i < 1000; i++) begin
         int gap;
         int e1, e2;
         logic [15:0] s;
         gap = $urandom_range(0, 3);
         on = 1'b0;
         for (int g = 0; g < gap; g++) begin
            tick();
            chk("hold_card1", card1_out, prev1);
            chk("hold_card2", card2_out, prev2);
         end
         test = ($urandom_range(0, 1) == 0) ? 3'b000 : {1'b1, 2'($urandom_range(0, 3))};
         on = 1'b1;
         tick();
         if (ecnt == 0 || ecnt >= 8192) begin
            chk("edge_budget", int'(ecnt), 1);
            break;
         end
         s  = seq[ecnt-1];
         e1 = card_of_nib(int'(s[3:0]));
         e2 = card_of_nib(int'(s[7:4]));
         chk("rand_card1", card1_out, e1);
         chk("rand_card2", card2_out, e2);
         if (card1_out <= 10) hist[card1_out]++;
         if (card2_out <= 10) hist[card2_out]++;
         prev1 = card1_out;
         prev2 = card2_out;
      end
      on = 1'b0;
      for (int v = 1; v <= 10; v++)
         chk($sformatf("seen_value_%0d", v), int'(hist[v] > 0), 1);
      for (int v = 1; v <= 9; v++)
         chk($sformatf("ten_beats_%0d", v), int'(hist[10] > hist[v]), 1);

      // Asynchronous reset mid-cycle, then a draw during reset is discarded
      test = 3'b011;
      on = 1'b1;
      @(posedge clk);
      #3 reset = 1'b1;
      #1;
      chk("async_rst_card1", card1_out, 0);
      chk("async_rst_card2", card2_out, 0);
      #2;
      chk("draw_in_rst_card1", card1_out, 0);
      chk("draw_in_rst_card2", card2_out, 0);
      on = 1'b0;
      reset = 1'b0;
      tick();
      chk("post_rst_card1", card1_out, 0);

      // Bouncing button, then a clean rising edge
      lows = 0;
      for (int i = 0; i < 40; i++) begin
         btn_in = ((i / 3) % 2 == 0);
         tick();
         if (btn_db !== 1'b0) lows++;
      end
      chk("bounce_db_stays_low", lows, 0);
      btn_in = 1'b1;
      n = 0;
      while (n < 60) begin
         tick();
         n++;
         if (btn_db === 1'b1) break;
      end
      chk("db_rise_latency", n, 18);

      // Short low glitch must not reach btn_db
      lows = 0;
      btn_in = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (btn_db !== 1'b1) lows++;
      end
      btn_in = 1'b1;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (btn_db !== 1'b1) lows++;
      end
      chk("glitch_filtered", lows, 0);

      // Reset while button held
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("rst_held_db_low", btn_db, 0);
      @(posedge clk);
      #1 reset = 1'b0;
      n = 0;
      while (n < 60) begin
         tick();
         n++;
         if (btn_db === 1'b1) break;
      end
      chk("db_after_rst_latency", n, 18);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
